logic_gate_engine: RTL
======================

LOGIC_GATE_ENGINE -- requirements
Module: logic_gate_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result bit width (legal range 1..64).
REQ-002 SHALL have port clk  input  1  single rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operand beat present.
REQ-005 SHALL have port in_ready  output  1  engine accepts operand beat.
REQ-006 SHALL have port op  input  3  gate select: 0 AND, 1 OR, 2 NOT(a), 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 BUF(a).
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B (ignored for ops 2 and 7).
REQ-009 SHALL have port out_valid  output  1  result beat present.
REQ-010 SHALL have port out_ready  input  1  downstream accepts result.
REQ-011 SHALL have port y  output  WIDTH  registered bitwise result.
REQ-012 SHALL have port sweep_start  input  1  request built-in truth-table self-check.
REQ-013 SHALL have port inj_fault  input  1  test hook; inverts datapath result bit 0 while high.
REQ-014 SHALL have port sweep_busy  output  1  self-check in progress.
REQ-015 SHALL have port sweep_done  output  1  one-cycle completion pulse.
REQ-016 SHALL have port sweep_err_cnt  output  6  mismatches in last self-check (0..32).

Function
REQ-017 Datapath SHALL compute y_next = op(a,b) bitwise across all WIDTH bits, then XOR bit 0 with inj_fault.
REQ-018 Output stage SHALL be one register; latency exactly 1 cycle from accepted input beat to out_valid.
REQ-019 Input beat accepted iff in_valid && in_ready; output beat consumed iff out_valid && out_ready.
REQ-020 in_ready SHALL equal (!out_valid || out_ready) in IDLE, and 0 in every other sweep state.
REQ-021 Full throughput: back-to-back beats with out_ready=1 SHALL produce one result per cycle, no bubbles.
REQ-022 When out_valid=1 and out_ready=0, y and out_valid SHALL hold stable.
REQ-023 Sweep FSM states: IDLE, RUN, DRAIN, DONE.
REQ-024 IDLE->RUN when sweep_start=1 and out_valid=0 and no beat accepted that cycle; otherwise sweep_start ignored (no queuing).
REQ-025 On IDLE->RUN, sweep_err_cnt SHALL clear to 0 and 5-bit vector index k SHALL clear to 0.
REQ-026 RUN: each cycle issue internal vector k: op=k[4:2], a=all bits k[1], b=all bits k[0]; k increments; after k=31 issued, RUN->DRAIN.
REQ-027 Each internal result SHALL be compared, the cycle it appears in the output register, against an independent constant golden truth table; mismatch (any bit) increments sweep_err_cnt by 1.
REQ-028 DRAIN compares the last result, then ->DONE; DONE lasts one cycle, then ->IDLE.
REQ-029 sweep_busy=1 in RUN and DRAIN only; sweep_done=1 in DONE only.
REQ-030 During sweep, external out_valid SHALL be 0 and internal results never reach the external handshake.
REQ-031 Timing: start sampled in cycle c0 -> RUN c1..c32, DRAIN c33, sweep_done high in c34 only.
REQ-032 sweep_err_cnt SHALL hold its value from DONE until the next accepted sweep_start or reset.
REQ-033 External input ports SHALL have no effect on sweep vectors or results except inj_fault.

Reset
REQ-034 rst=1 at a clk edge SHALL force: state IDLE, out_valid=0, y=0, sweep_busy=0, sweep_done=0, sweep_err_cnt=0, k=0.
REQ-035 Reset mid-sweep or mid-stall SHALL abort with no done pulse and discard any held result.
REQ-036 in_ready SHALL be 0 while rst=1.

Verification
REQ-037 WIDTH=8, a=0xF0, b=0xCC, ops 0..7 back-to-back, out_ready=1 -> y = 0xC0,0xFC,0x0F,0x3F,0x03,0x3C,0xC3,0xF0 on consecutive cycles, each 1 cycle after acceptance.
REQ-038 Hold out_ready=0 with one result pending, keep in_valid=1 -> in_ready=0, y stable; release -> next beat accepted same cycle.
REQ-039 sweep_start with inj_fault=0 -> sweep_busy 33 cycles, sweep_done in c34, sweep_err_cnt=0.
REQ-040 sweep_start with inj_fault=1 throughout -> sweep_err_cnt=32 at DONE.
REQ-041 sweep_start while out_valid=1 -> ignored, sweep_busy stays 0.
REQ-042 rst asserted at c10 of a sweep -> next cycle IDLE, all outputs 0, no sweep_done.

Source files
------------

// File: rtl/logic_gate_engine.sv
// Registered bitwise gate engine with valid/ready handshake and a built-in
// 32-vector truth-table self-check sweep that reuses the output register.
module logic_gate_engine #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    input  logic             sweep_start,
    input  logic             inj_fault,
    output logic             sweep_busy,
    output logic             sweep_done,
    output logic [5:0]       sweep_err_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // Golden truth table, bit index {op, a, b}; kept independent of gate().
    localparam logic [31:0] GOLDEN = 32'hC961_73E8;

    state_t           state_q;
    logic [4:0]       k_q;
    logic [WIDTH-1:0] y_q, y_d;
    logic             out_valid_q, out_valid_d;
    logic             chk_valid_q;
    logic [4:0]       chk_k_q;
    logic [5:0]       err_cnt_q;

    logic             in_acc;
    logic             out_cons;
    logic             start_ok;
    logic             chk_miss;
    logic [WIDTH-1:0] ext_res;
    logic [WIDTH-1:0] int_res;

    function automatic logic [WIDTH-1:0] gate(
        input logic [2:0]       sel,
        input logic [WIDTH-1:0] opa,
        input logic [WIDTH-1:0] opb
    );
        logic [WIDTH-1:0] r;
        case (sel)
            3'd0:    r = opa & opb;
            3'd1:    r = opa | opb;
            3'd2:    r = ~opa;
            3'd3:    r = ~(opa & opb);
            3'd4:    r = ~(opa | opb);
            3'd5:    r = opa ^ opb;
            3'd6:    r = ~(opa ^ opb);
            default: r = opa;
        endcase
        return r;
    endfunction

    always_comb begin
        ext_res    = gate(op, a, b);
        ext_res[0] = ext_res[0] ^ inj_fault;
        int_res    = gate(k_q[4:2], {WIDTH{k_q[1]}}, {WIDTH{k_q[0]}});
        int_res[0] = int_res[0] ^ inj_fault;
    end

    assign in_ready = (state_q == IDLE) && !rst && (!out_valid_q || out_ready);
    assign in_acc   = in_valid && in_ready;
    assign out_cons = out_valid_q && out_ready;
    assign start_ok = (state_q == IDLE) && sweep_start && !out_valid_q && !in_acc;
    assign chk_miss = chk_valid_q && (y_q != {WIDTH{GOLDEN[chk_k_q]}});

    // Output register is shared: external beats in IDLE, sweep vectors in RUN.
    always_comb begin
        y_d         = y_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_acc) begin
                    y_d         = ext_res;
                    out_valid_d = 1'b1;
                end else if (out_cons) begin
                    out_valid_d = 1'b0;
                end
            end
            RUN:     y_d = int_res;
            default: y_d = y_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= 5'd0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            chk_valid_q <= 1'b0;
            chk_k_q     <= 5'd0;
            err_cnt_q   <= 6'd0;
        end else begin
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
            chk_valid_q <= 1'b0;
            if (chk_miss) begin
                err_cnt_q <= err_cnt_q + 6'd1;
            end
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        state_q   <= RUN;
                        k_q       <= 5'd0;
                        err_cnt_q <= 6'd0;
                    end
                end
                RUN: begin
                    chk_valid_q <= 1'b1;
                    chk_k_q     <= k_q;
                    k_q         <= k_q + 5'd1;
                    if (k_q == 5'd31) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN:   state_q <= DONE;
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid     = out_valid_q;
    assign y             = y_q;
    assign sweep_busy    = (state_q == RUN) || (state_q == DRAIN);
    assign sweep_done    = (state_q == DONE);
    assign sweep_err_cnt = err_cnt_q;

endmodule
